clk_div_prog: RTL

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer clock divider.
// Produces a registered divided clock with period N (high time floor(N/2)),
// a one-cycle tick on each rising edge of clk_out, and a pending/active ratio
// pair so that a new ratio only takes effect at a period boundary.
// Optional feature: define CLK_DIV_LOCK_EN to build the lock indicator;
// without it, locked is tied low.
module clk_div_prog #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DIV_DEFAULT  = 4,
    parameter int unsigned LOCK_PERIODS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             upd_pending,
    output logic             locked
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic             wrap;
    logic             apply_pend;
    logic             apply_load;

    // Ratios below 2 cannot form a period with both a high and a low phase.
    function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] r);
        return (r < CNT_W'(2)) ? CNT_W'(2) : r;
    endfunction

    // Period counter, ratio update handshake and registered output decode.
    always_comb begin
        wrap       = enable && (cnt_q >= (n_q - 1'b1));
        apply_pend = pend_vld_q && (wrap || !enable);
        apply_load = div_load && wrap;

        cnt_d      = (!enable || wrap) ? '0 : cnt_q + 1'b1;
        n_d        = n_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        if (apply_pend) begin
            n_d        = clamp_ratio(pend_q);
            pend_vld_d = 1'b0;
        end

        // A load landing on the wrap is applied directly and never shows as pending;
        // otherwise it overwrites whatever is pending (last value wins).
        if (div_load) begin
            if (wrap) begin
                n_d        = clamp_ratio(div_ratio);
                pend_vld_d = 1'b0;
            end else begin
                pend_d     = div_ratio;
                pend_vld_d = 1'b1;
            end
        end

        clk_out_d = enable && (cnt_q < (n_q >> 1));
        tick_d    = enable && (cnt_q == '0);
    end

    // State registers with asynchronous reset to the default ratio.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            n_q        <= CNT_W'(DIV_DEFAULT);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign upd_pending = pend_vld_q;

`ifdef CLK_DIV_LOCK_EN
    localparam int unsigned LK_W = (LOCK_PERIODS < 2) ? 1 : $clog2(LOCK_PERIODS + 1);

    logic [LK_W-1:0] lk_cnt_q, lk_cnt_d;
    logic            locked_q, locked_d;
    logic            lk_clear;

    // Count completed periods since the last ratio change or enable rise.
    always_comb begin
        lk_clear = !enable || div_load || apply_pend || apply_load;
        lk_cnt_d = lk_cnt_q;
        if (lk_clear) begin
            lk_cnt_d = '0;
        end else if (wrap && (lk_cnt_q < LK_W'(LOCK_PERIODS))) begin
            lk_cnt_d = lk_cnt_q + 1'b1;
        end
        locked_d = !lk_clear && (lk_cnt_d >= LK_W'(LOCK_PERIODS));
    end

    // Lock counter and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lk_cnt_q <= '0;
            locked_q <= 1'b0;
        end else begin
            lk_cnt_q <= lk_cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

endmodule
